morse_keyer: RTL and testbench
==============================

# morse_keyer

Morse keying stage fed by the dot-rate NCO. It accepts one ASCII character at a time over a valid/ready handshake and drives the on/off key line `key_out`. All element and gap durations are whole dot units. A unit is delimited by rising edges of the NCO's dot-rate square wave, `dot_clk`, which is synchronous to `clk_in`.

## Interface
- `DASH_UNITS`, default 3: dash length in dot units; legal range 2–7.
- `clk_in`  in  1  system clock (same clock as the NCO).
- `rst`  in  1  synchronous, active-high reset.
- `dot_clk`  in  1  dot-rate square wave from the NCO (`clk_out1`); registered on `clk_in`; period = 1 dot unit.
- `char_in`  in  8  ASCII character.
- `char_valid`  in  1  `char_in` is valid.
- `char_ready`  out  1  the block can accept a character this cycle.
- `key_out`  out  1  Morse key: 1 = mark (tone on), 0 = space.
- `busy`  out  1  the block is sending, counting a gap, or holding a character.
- `err`  out  1  one-cycle pulse: the accepted character is unsupported.

## Operation
- **Tick generation**
  - `dot_clk` passes through two flops `d1` and `d2`. Both reset to 1.
  - `tick = d1 & ~d2`, one `clk_in` cycle wide.
  - Because both flops reset to 1, no spurious tick can occur when `dot_clk` is high at reset release.
- **Handshake**
  - `char_ready = (state==IDLE) & ~pend`.
  - A transfer happens when `char_valid & char_ready` is high on a clock edge.
- **Decode on accept**
  - `A`–`Z` and `a`–`z` (case-folded) and `0`–`9` map to the standard ITU pattern: a 3-bit length (1–5) and 5 element bits, MSB-first, where 1 = dash.
  - 0x20 (space) is marked as a word-gap request.
  - Any other code raises `err` on the next cycle. It is consumed: `pend` stays 0 and the block produces no key activity.
- **States**
  - **IDLE.** On a tick with `pend` set:
    - For a letter, go to MARK, set `key_out` to 1, and load the unit counter with 1 or `DASH_UNITS`.
    - For a space, go to GAP_WORD with the counter set to 3.
    - Clear `pend` in both cases.
  - **MARK.** Decrement the counter on each tick. When it reaches 0, set `key_out` to 0.
    - If elements remain, go to GAP_ELEM (1 unit).
    - Otherwise go to GAP_LETTER with the counter set to 2.
  - **GAP_ELEM.** On the next tick, set `key_out` to 1 for the next element and go to MARK.
  - **GAP_LETTER.** Decrement on each tick; at 0 go to IDLE.
  - **GAP_WORD.** Decrement on each tick; at 0 go to IDLE.
- **Resulting gaps**
  - Inter-element gap = 1 unit.
  - Inter-letter gap = 2 units plus the wait for the next tick in IDLE = exactly 3 units, provided the next character was accepted before that tick.
  - Word gap, counted from the end of the last mark = 2 + 1 + 3 + 1 = 7 units.
  - A character that arrives late lengthens the gap; the line stays at space.
- **Other rules**
  - `busy = (state!=IDLE) | pend`.
  - Ticks are ignored while in IDLE with `pend` clear.
  - A tick arriving on the same cycle as an accept does not start that character. It starts on the following tick.
  - Reset at any time forces IDLE, `pend`=0, `key_out`=0, `err`=0, counters=0, `d1`=`d2`=1. Any character in progress is discarded.

## Timing
- Reset values: `key_out`=0, `char_ready`=1, `busy`=0, `err`=0.
- `dot_clk` rises just after edge E0 and is sampled into `d1` at E1. `tick` is high between E1 and E2, and `key_out`/state update at E2.
  - Latency from `dot_clk` rise to `key_out` change = 2 `clk_in` edges.
- `err` is high for the single cycle after the accepting edge.
- `char_ready` drops on the cycle after an accept. It returns high on the cycle after the block re-enters IDLE; for an unsupported character, that is the cycle after the accept.
- Mark widths are exactly 1×K or `DASH_UNITS`×K `clk_in` cycles, where K = `clk_in` cycles per `dot_clk` period.

## Test plan
The bench uses K=50, with `dot_clk` driven by `nco_advanced`.
1. Reset with `dot_clk` high, then release → `key_out`=0, `char_ready`=1, `busy`=0, no tick before the next `dot_clk` rising edge.
2. Send `E` (0x45) → `key_out` high for exactly 50 cycles. `char_ready` returns 2 ticks (100 cycles) after `key_out` falls.
3. Send `A` then `B`, with `B` presented immediately → key runs 1,0,3,0 units for `A`, then exactly 3 units low, then `B`'s dash (3 units = 150 cycles), then 1-unit low/high dot elements.
4. Send `E`, `' '`, `T` → low interval between `E`'s mark end and `T`'s mark start = 350 cycles (7 units).
5. Send `#` (0x23) → `err` high for exactly 1 cycle, `key_out` stays 0, `char_ready`=1 on the following cycle. Send `a` → same waveform as `A`. Send `0` → five 150-cycle marks.
6. Assert `rst` during `O`'s second dash → `key_out`=0 and `busy`=0 one edge later. A following `E` keys exactly 50 cycles, aligned to a `dot_clk` edge.

Source files
------------

// File: rtl/morse_keyer_if.sv
// Character handshake and key-line signals between a character source and the Morse keyer.
// Valid/ready: a character transfers on any clk_in edge where char_valid and char_ready are both high;
// the source holds char_in stable while char_valid is high and ready is low.
interface morse_keyer_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       err;

    modport master (
        output char_in,
        output char_valid,
        input  char_ready,
        input  key_out,
        input  busy,
        input  err
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output char_ready,
        output key_out,
        output busy,
        output err
    );
endinterface

// File: rtl/morse_keyer.sv
// Morse keyer: takes one ASCII character per handshake and keys it out in whole dot units,
// with unit boundaries taken from rising edges of the NCO dot-rate square wave.
module morse_keyer #(
    parameter int unsigned DASH_UNITS = 3
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              dot_clk,
    morse_keyer_if.slave      bus,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MARK       = 3'd1,
        GAP_ELEM   = 3'd2,
        GAP_LETTER = 3'd3,
        GAP_WORD   = 3'd4
    } state_t;

    localparam logic [2:0] DASH = 3'(DASH_UNITS);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] elem_q, elem_d;
    logic [2:0] rem_q, rem_d;
    logic       key_q, key_d;
    logic       pend_q, pend_d;
    logic       space_q, space_d;
    logic [2:0] len_q, len_d;
    logic [4:0] pat_q, pat_d;
    logic       err_q, err_d;
    logic       d1_q, d2_q;

    logic       tick;
    logic       accept;
    logic       is_space;
    logic [7:0] dec;

    // Returns {length, elements}; elements are left-aligned (first element in bit 4), 1 = dash.
    // A length of 0 marks an unsupported code.
    function automatic logic [7:0] decode(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (c >= 8'h61 && c <= 8'h7a) u = c - 8'h20;
        case (u)
            8'h41: decode = {3'd2, 5'b01000}; // A .-
            8'h42: decode = {3'd4, 5'b10000}; // B -...
            8'h43: decode = {3'd4, 5'b10100}; // C -.-.
            8'h44: decode = {3'd3, 5'b10000}; // D -..
            8'h45: decode = {3'd1, 5'b00000}; // E .
            8'h46: decode = {3'd4, 5'b00100}; // F ..-.
            8'h47: decode = {3'd3, 5'b11000}; // G --.
            8'h48: decode = {3'd4, 5'b00000}; // H ....
            8'h49: decode = {3'd2, 5'b00000}; // I ..
            8'h4a: decode = {3'd4, 5'b01110}; // J .---
            8'h4b: decode = {3'd3, 5'b10100}; // K -.-
            8'h4c: decode = {3'd4, 5'b01000}; // L .-..
            8'h4d: decode = {3'd2, 5'b11000}; // M --
            8'h4e: decode = {3'd2, 5'b10000}; // N -.
            8'h4f: decode = {3'd3, 5'b11100}; // O ---
            8'h50: decode = {3'd4, 5'b01100}; // P .--.
            8'h51: decode = {3'd4, 5'b11010}; // Q --.-
            8'h52: decode = {3'd3, 5'b01000}; // R .-.
            8'h53: decode = {3'd3, 5'b00000}; // S ...
            8'h54: decode = {3'd1, 5'b10000}; // T -
            8'h55: decode = {3'd3, 5'b00100}; // U ..-
            8'h56: decode = {3'd4, 5'b00010}; // V ...-
            8'h57: decode = {3'd3, 5'b01100}; // W .--
            8'h58: decode = {3'd4, 5'b10010}; // X -..-
            8'h59: decode = {3'd4, 5'b10110}; // Y -.--
            8'h5a: decode = {3'd4, 5'b11000}; // Z --..
            8'h30: decode = {3'd5, 5'b11111};
            8'h31: decode = {3'd5, 5'b01111};
            8'h32: decode = {3'd5, 5'b00111};
            8'h33: decode = {3'd5, 5'b00011};
            8'h34: decode = {3'd5, 5'b00001};
            8'h35: decode = {3'd5, 5'b00000};
            8'h36: decode = {3'd5, 5'b10000};
            8'h37: decode = {3'd5, 5'b11000};
            8'h38: decode = {3'd5, 5'b11100};
            8'h39: decode = {3'd5, 5'b11110};
            default: decode = 8'h00;
        endcase
    endfunction

    // Flops reset high so a dot_clk already high at reset release cannot look like a rising edge.
    assign tick     = d1_q & ~d2_q;
    assign accept   = bus.char_valid & bus.char_ready;
    assign is_space = (bus.char_in == 8'h20);
    assign dec      = decode(bus.char_in);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        elem_d  = elem_q;
        rem_d   = rem_q;
        key_d   = key_q;
        pend_d  = pend_q;
        space_d = space_q;
        len_d   = len_q;
        pat_d   = pat_q;
        err_d   = 1'b0;

        // Accept only happens in IDLE with nothing pending, so it never collides with a start.
        if (accept) begin
            if (!is_space && dec[7:5] == 3'd0) begin
                err_d = 1'b1;
            end else begin
                pend_d  = 1'b1;
                space_d = is_space;
                len_d   = dec[7:5];
                pat_d   = dec[4:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (tick && pend_q) begin
                    pend_d = 1'b0;
                    if (space_q) begin
                        state_d = GAP_WORD;
                        cnt_d   = 3'd3;
                    end else begin
                        state_d = MARK;
                        key_d   = 1'b1;
                        cnt_d   = pat_q[4] ? DASH : 3'd1;
                        elem_d  = {pat_q[3:0], 1'b0};
                        rem_d   = len_q - 3'd1;
                    end
                end
            end
            MARK: begin
                if (tick) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        key_d = 1'b0;
                        if (rem_q != 3'd0) begin
                            state_d = GAP_ELEM;
                        end else begin
                            state_d = GAP_LETTER;
                            cnt_d   = 3'd2;
                        end
                    end
                end
            end
            GAP_ELEM: begin
                if (tick) begin
                    state_d = MARK;
                    key_d   = 1'b1;
                    cnt_d   = elem_q[4] ? DASH : 3'd1;
                    elem_d  = {elem_q[3:0], 1'b0};
                    rem_d   = rem_q - 3'd1;
                end
            end
            GAP_LETTER, GAP_WORD: begin
                if (tick) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            elem_q  <= 5'd0;
            rem_q   <= 3'd0;
            key_q   <= 1'b0;
            pend_q  <= 1'b0;
            space_q <= 1'b0;
            len_q   <= 3'd0;
            pat_q   <= 5'd0;
            err_q   <= 1'b0;
            d1_q    <= 1'b1;
            d2_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            elem_q  <= elem_d;
            rem_q   <= rem_d;
            key_q   <= key_d;
            pend_q  <= pend_d;
            space_q <= space_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            err_q   <= err_d;
            d1_q    <= dot_clk;
            d2_q    <= d1_q;
        end
    end

    assign bus.char_ready = (state_q == IDLE) & ~pend_q;
    assign bus.key_out    = key_q;
    assign bus.busy       = (state_q != IDLE) | pend_q;
    assign bus.err        = err_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: random and directed characters, reference marks/gaps derived from Morse
// strings, checked by a key-line monitor against an expected queue.
module tb_morse_keyer;
    localparam int K    = 50;
    localparam int DASH = 3;
    localparam logic [15:0] DC = 16'hFFFF;

    logic       clk_in  = 1'b0;
    logic       rst     = 1'b1;
    logic       dot_clk = 1'b1;
    logic [2:0] state_dbg;
    int         nco_cnt = 0;

    morse_keyer_if bus();

    morse_keyer #(.DASH_UNITS(DASH)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .dot_clk (dot_clk),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // Clock and dot-rate NCO: dot_clk rises just after the edge where nco_cnt wraps to 0.
    initial forever #5 clk_in = ~clk_in;

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            nco_cnt = (nco_cnt == K - 1) ? 0 : nco_cnt + 1;
            dot_clk = (nco_cnt < K / 2);
        end
    end

    // Scoreboard: each entry is {gap before mark, mark width} in clk_in cycles.
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    bit   mon_en     = 0;
    logic prev_key   = 1'b0;
    logic prev_err   = 1'b0;
    int   run        = 0;
    int   gap_meas   = 0;
    bit   skip       = 0;
    int   err_pulses = 0;

    always @(negedge clk_in) begin
        logic [31:0] item;
        if (mon_en) begin
            if (rst) begin
                exp_q.delete();
                skip = skip | prev_key;
            end
            if (bus.err === 1'b1 && prev_err !== 1'b1) err_pulses++;
            prev_err = bus.err;
            if (bus.key_out === prev_key) begin
                run++;
            end else begin
                if (bus.key_out === 1'b1) begin
                    check("rise_phase", nco_cnt, 2);
                    gap_meas = run;
                end else if (skip) begin
                    skip = 0;
                end else begin
                    check("fall_phase", nco_cnt, 2);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mark: got width %0d expected no mark at %0t", run, $time);
                    end else begin
                        item = exp_q.pop_front();
                        check("mark_len", run, int'(item[15:0]));
                        if (item[31:16] != DC) check("gap_len", gap_meas, int'(item[31:16]));
                    end
                end
                run = 1;
                prev_key = bus.key_out;
            end
        end
    end

    // Reference model: Morse strings and the gap rules between characters.
    bit first_mark = 1;
    int n_spaces   = 0;
    int n_bad      = 0;

    function automatic string morse_of(input byte c);
        byte u;
        u = (c >= "a" && c <= "z") ? byte'(c - 8'd32) : c;
        case (u)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
            "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
            "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
            "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
            "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
            "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
            "8": return "---.."; "9": return "----.";
            " ": return "";
            default: return "?";
        endcase
    endfunction

    task automatic start_seq();
        first_mark = 1;
        n_spaces   = 0;
    endtask

    task automatic send_char(input byte c);
        string m;
        int    waited;
        int    gap;
        int    mark;
        bit    bad;
        m      = morse_of(c);
        bad    = (m == "?");
        waited = 0;
        @(negedge clk_in);
        while (bus.char_ready !== 1'b1 && waited < 20000) begin
            @(negedge clk_in);
            waited++;
        end
        if (bus.char_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b expected 1 within 20000 cycles", bus.char_ready);
            return;
        end
        if (c == " ") begin
            n_spaces++;
        end else if (bad) begin
            n_bad++;
        end else begin
            for (int i = 0; i < m.len(); i++) begin
                if (i == 0) gap = first_mark ? int'(DC) : (3 + 4 * n_spaces) * K;
                else        gap = K;
                mark = (m[i] == "-") ? DASH * K : K;
                exp_q.push_back({16'(gap), 16'(mark)});
            end
            first_mark = 0;
            n_spaces   = 0;
        end
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        @(posedge clk_in);
        #1;
        bus.char_valid = 1'b0;
        if (bad) begin
            check("err_pulse", bus.err, 1);
            check("ready_after_bad", bus.char_ready, 1);
            check("busy_after_bad", bus.busy, 0);
            @(posedge clk_in);
            #1;
            check("err_width", bus.err, 0);
        end else begin
            check("err_quiet", bus.err, 0);
            check("ready_drop", bus.char_ready, 0);
        end
    endtask

    task automatic wait_key(input logic level);
        int n;
        n = 0;
        while (bus.key_out !== level && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        if (bus.key_out !== level) begin
            checks++;
            errors++;
            $display("FAIL key_wait: got key=%b expected %b within 2000 cycles", bus.key_out, level);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy !== 1'b0 || exp_q.size() != 0) && n < 30000) begin
            @(negedge clk_in);
            n++;
        end
        check("idle_reached", int'(n < 30000), 1);
        repeat (3) @(negedge clk_in);
    endtask

    function automatic byte rand_char();
        int  r;
        byte c;
        r = $urandom_range(0, 9);
        if (r <= 3)      c = byte'($urandom_range(65, 90));
        else if (r <= 5) c = byte'($urandom_range(97, 122));
        else if (r <= 7) c = byte'($urandom_range(48, 57));
        else if (r == 8) c = " ";
        else begin
            c = byte'($urandom_range(0, 255));
            while (morse_of(c) != "?") c = byte'($urandom_range(0, 255));
        end
        return c;
    endfunction

    initial begin
        int n;
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        rst            = 1'b1;

        // Reset with dot_clk high, release mid high phase.
        repeat (4) @(posedge clk_in);
        #1;
        rst = 1'b0;
        check("rst_key", bus.key_out, 0);
        check("rst_ready", bus.char_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_state", state_dbg, 0);
        mon_en = 1;

        // Single E; ready returns two units after the mark ends.
        start_seq();
        send_char("E");
        wait_key(1'b1);
        wait_key(1'b0);
        n = 0;
        while (bus.char_ready !== 1'b1 && n < 1000) begin
            @(negedge clk_in);
            n++;
        end
        check("ready_return", n, 2 * K);
        wait_idle();

        start_seq(); send_char("A"); send_char("B"); wait_idle();
        start_seq(); send_char("E"); send_char(" "); send_char("T"); wait_idle();
        start_seq(); send_char("#"); send_char("a"); send_char("0"); wait_idle();

        // Reset during the second dash of O, then a clean E.
        start_seq();
        send_char("O");
        wait_key(1'b1);
        wait_key(1'b0);
        wait_key(1'b1);
        repeat (60) @(posedge clk_in);
        #1;
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        check("rst_mid_key", bus.key_out, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_ready", bus.char_ready, 1);
        rst = 1'b0;
        start_seq();
        send_char("E");
        wait_idle();

        for (int s = 0; s < 4; s++) begin
            start_seq();
            for (int j = 0; j < 4; j++) send_char(rand_char());
            wait_idle();
        end

        check("err_count", err_pulses, n_bad);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
